// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, frame width and mode-0 constants
// used by the master and by the slave-side bench.
package spi_pkg;

    localparam int   SPI_DATA_W = 8;
    localparam logic SPI_CPOL   = 1'b0;
    localparam logic SPI_CPHA   = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TRAIL = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for the SPI master: emits a one-cycle phase_end tick every
// CLK_DIV clk cycles while enabled, and holds the counter at zero otherwise.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase_end
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Half-period counter, wraps at CLK_DIV-1 and clears whenever the master is idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign phase_end = en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master for the I/O expander: one 8-bit frame per accepted start.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              ss,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int              BIT_W    = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    spi_state_e        state_r, next_state_s;
    logic              phase_end_s;
    logic              load_s, shift_s, sample_s, finish_s;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [DATA_W-1:0] tx_sr_r, rx_sr_r;
    logic [DATA_W-1:0] tx_shift_s, rx_shift_s;
    logic              ss_r, sclk_r, busy_r, done_r;
    logic [DATA_W-1:0] rx_data_r;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .en        (busy_r),
        .phase_end (phase_end_s)
    );

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_shift_s = {1'b0, tx_sr_r[DATA_W-1:1]};
    assign rx_shift_s = {miso, rx_sr_r[DATA_W-1:1]};
    assign mosi       = tx_sr_r[0];
`else
    assign tx_shift_s = {tx_sr_r[DATA_W-2:0], 1'b0};
    assign rx_shift_s = {rx_sr_r[DATA_W-2:0], miso};
    assign mosi       = tx_sr_r[DATA_W-1];
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and datapath strobes
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        sample_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = LEAD;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LEAD: begin
                if (phase_end_s) begin
                    next_state_s = HIGH;
                end else begin
                    next_state_s = LEAD;
                end
            end
            HIGH: begin
                if (phase_end_s) begin
                    next_state_s = LOW;
                    sample_s     = 1'b1;
                    // the last bit stays on mosi through the final LOW and TRAIL
                    shift_s      = (bit_cnt_r != BIT_LAST);
                end else begin
                    next_state_s = HIGH;
                end
            end
            LOW: begin
                if (phase_end_s) begin
                    if (bit_cnt_r == BIT_FULL) begin
                        next_state_s = TRAIL;
                    end else begin
                        next_state_s = HIGH;
                    end
                end else begin
                    next_state_s = LOW;
                end
            end
            TRAIL: begin
                if (phase_end_s) begin
                    next_state_s = IDLE;
                    finish_s     = 1'b1;
                end else begin
                    next_state_s = TRAIL;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and received-byte holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sr_r   <= '0;
            rx_sr_r   <= '0;
            bit_cnt_r <= '0;
            rx_data_r <= '0;
        end else begin
            if (load_s) begin
                tx_sr_r   <= tx_data;
                rx_sr_r   <= '0;
                bit_cnt_r <= '0;
            end else begin
                if (shift_s) begin
                    tx_sr_r <= tx_shift_s;
                end
                if (sample_s) begin
                    rx_sr_r   <= rx_shift_s;
                    bit_cnt_r <= bit_cnt_r + BIT_ONE;
                end
            end
            if (finish_s) begin
                rx_data_r <= rx_sr_r;
            end
        end
    end

    // Pin and handshake outputs registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss_r   <= 1'b1;
            sclk_r <= SPI_CPOL;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            ss_r   <= (next_state_s == IDLE);
            sclk_r <= (next_state_s == HIGH) ^ SPI_CPOL;
            busy_r <= (next_state_s != IDLE);
            done_r <= finish_s;
        end
    end

    assign ss      = ss_r;
    assign sclk    = sclk_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rx_data = rx_data_r;

endmodule

// File: doc/spi_master.md
# spi_master

Host-side SPI master that drives the 8-bit I/O expander's serial port: it turns a parallel byte plus a start strobe into one mode-0 SPI frame on ss/sclk/mosi, and captures the byte returned on miso. It sits directly upstream of the expander's SPI slave, on the same PCB or FPGA test harness. The controlling logic talks to it through a start/busy/done handshake.

## Interface
- CLK_DIV, 2: sclk half-period in clk cycles; legal range 2..255.
- DATA_W, 8: frame width in bits; fixed at 8 for the expander.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a frame; sampled only while busy=0.
- tx_data  in  DATA_W  byte to send; captured in the cycle start is accepted.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame ends and rx_data is valid.
- rx_data  out  DATA_W  byte received on miso; holds until the next done.
- ss  out  1  slave select, active-low.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  serial data to the slave.
- miso  in  1  serial data from the slave.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0), MSB first by default.
- The slave samples mosi on the sclk rising edge and changes miso on the falling edge.
- The FSM has five states: IDLE, LEAD, HIGH, LOW, TRAIL.
- IDLE:
  - ss=1, sclk=0, busy=0.
  - When start=1, load the shift register from tx_data, clear the bit counter, then go to LEAD.
- LEAD:
  - ss=0, mosi = first bit.
  - Lasts CLK_DIV cycles, then go to HIGH.
- HIGH:
  - sclk=1 for CLK_DIV cycles.
  - miso is sampled into the receive shift register on the last clk cycle of HIGH.
  - No synchroniser is used on miso: it is stable mid-phase because the slave updates it only on falling edges.
- LOW:
  - sclk=0 for CLK_DIV cycles.
  - On entry the bit counter increments, and mosi shifts to the next bit.
  - After the 8th LOW, go to TRAIL; otherwise go to HIGH.
  - mosi keeps the last bit during TRAIL.
- TRAIL:
  - ss stays 0 for CLK_DIV cycles.
  - Then go to IDLE. On that transition ss=1, done=1, rx_data updates, busy=0.
- start while busy=1 is ignored; it is not queued.
- start in the same cycle as done is accepted, giving back-to-back frames with ss high for exactly one cycle.
- tx_data changes after acceptance have no effect on the frame in progress.

## Timing
- Reset values: ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0; the FSM goes to IDLE and the counters clear.
- Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- Start accepted at cycle 0 gives ss=0 and busy=1 from cycle 1.
- The first sclk rising edge occurs at cycle 1+CLK_DIV.
- ss is low for 18·CLK_DIV cycles.
- done is high in cycle 1+18·CLK_DIV, which is the same cycle ss returns high.
- sclk has a 50 % duty cycle, period 2·CLK_DIV clk cycles, and exactly 8 rising edges per frame.
- Counter width is $clog2(CLK_DIV); the half-period counter wraps to 0 at CLK_DIV-1.

## Configuration
- SPI_MASTER_LSB_FIRST_EN defined:
  - tx shifts out bit 0 first.
  - rx fills from bit 7 downward, so rx_data[0] is the first miso bit received.
- Not defined: MSB first in both directions; rx_data[7] is the first miso bit received.
- Frame timing is identical in both builds.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE, LEAD, HIGH, LOW, TRAIL);
  - SPI_DATA_W = 8;
  - SPI_CPOL = 0 and SPI_CPHA = 0 constants, shared with the slave-side bench.
- One sub-module, spi_tick_gen:
  - parameterised by CLK_DIV;
  - outputs a one-cycle phase_end tick when the half-period counter reaches CLK_DIV-1;
  - enabled only while busy.
- The FSM, shift registers and bit counter stay in spi_master.

## Test plan
- Reset mid-frame: assert rst low at cycle 10 of a frame -> ss=1, sclk=0, busy=0 within the same cycle; no done; next start runs a normal frame.
- Basic frame: CLK_DIV=2, tx_data=0xA5, miso modelled as a mode-0 slave returning 0x3C -> mosi bits 1,0,1,0,0,1,0,1 at the 8 rising edges; done at cycle 37; rx_data=0x3C.
- Timing: CLK_DIV=4 -> ss low for 72 cycles; sclk period 8 cycles; exactly 8 sclk rising edges; sclk low whenever ss=1.
- Ignored start: pulse start at cycle 5 of a frame with tx_data=0xFF -> the frame still sends the original byte; only one done.
- Back-to-back: hold start=1 with tx_data 0x01 then 0x80 -> two frames; ss high exactly one cycle between them; rx_data updates at each done.
- LSB build: SPI_MASTER_LSB_FIRST_EN defined, tx_data=0x01 -> mosi is high only at the first rising edge; miso pattern 1,0,0,0,0,0,0,0 gives rx_data=0x01.
